// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants, state encoding and helpers
// for the multi-channel programmable timebase.
package tick_gen_pkg;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// tick_channel: one timebase channel with shadow/active config,
// periodic/one-shot FSM and registered tick/level/busy outputs.
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int          WIDTH      = 24,
    parameter int unsigned DEF_PERIOD = 5000000,
    parameter int unsigned DEF_HIGH   = 2500000
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_period,
    input  logic [WIDTH-1:0] i_high,
    input  logic             i_mode,
    input  logic             i_enable,
    input  logic             i_start,
    input  logic             i_sync,
    output logic             o_tick,
    output logic             o_level,
    output logic             o_busy
);

    ch_state_t        r_state;
    ch_state_t        w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_act_p;
    logic [WIDTH-1:0] r_act_h;
    logic             r_act_mode;
    logic [WIDTH-1:0] r_sh_p;
    logic [WIDTH-1:0] r_sh_h;
    logic             r_sh_mode;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_h;
    logic             w_mode;
    logic             w_running;
    logic             w_wrap;
    logic             w_xfer;
    logic             w_run_nxt;
    logic             w_tick_nxt;
    logic             w_level_nxt;
    logic             r_tick;
    logic             r_level;
    logic             r_busy;

    assign w_running = (r_state == ST_RUN);
    assign w_wrap    = w_running
                     && (r_cnt == r_act_p - WIDTH'(1));
    assign w_xfer    = i_sync || w_wrap || !w_running;

    // Config seen by the next cycle; an idle channel takes a
    // write straight into the active set.
    always_comb begin : next_cfg
        w_p    = r_act_p;
        w_h    = r_act_h;
        w_mode = r_act_mode;
        if (i_we && !w_running) begin
            w_p    = i_period;
            w_h    = i_high;
            w_mode = i_mode;
        end else if (w_xfer) begin
            w_p    = r_sh_p;
            w_h    = r_sh_h;
            w_mode = r_sh_mode;
        end
    end

    always_comb begin : next_state
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (i_enable && (w_p != '0)
                    && ((w_mode == MODE_PERIODIC) || i_start)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!i_enable || (w_p == '0)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (i_sync) begin
                    w_cnt_nxt = '0;
                end else if (w_wrap) begin
                    w_cnt_nxt = '0;
                    if (r_act_mode == MODE_ONESHOT) begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + WIDTH'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are computed from next state so the registered
    // tick lines up with the cycle where the counter is P-1.
    always_comb begin : next_out
        w_run_nxt   = (w_state_nxt == ST_RUN);
        w_tick_nxt  = w_run_nxt
                    && (w_cnt_nxt == w_p - WIDTH'(1));
        w_level_nxt = w_run_nxt && (w_cnt_nxt < w_h);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_act_p    <= WIDTH'(DEF_PERIOD);
            r_act_h    <= WIDTH'(DEF_HIGH);
            r_act_mode <= MODE_PERIODIC;
            r_sh_p     <= WIDTH'(DEF_PERIOD);
            r_sh_h     <= WIDTH'(DEF_HIGH);
            r_sh_mode  <= MODE_PERIODIC;
            r_tick     <= 1'b0;
            r_level    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_act_p    <= w_p;
            r_act_h    <= w_h;
            r_act_mode <= w_mode;
            if (i_we) begin
                r_sh_p    <= i_period;
                r_sh_h    <= i_high;
                r_sh_mode <= i_mode;
            end
            r_tick     <= w_tick_nxt;
            r_level    <= w_level_nxt;
            r_busy     <= w_run_nxt;
        end
    end

    assign o_tick  = r_tick;
    assign o_level = r_level;
    assign o_busy  = r_busy;

endmodule

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: N independent programmable tick/level channels
// sharing one config port and a global phase-align pulse.
module tick_gen_multi
    import tick_gen_pkg::*;
#(
    parameter int          CHANNELS   = 4,
    parameter int          WIDTH      = 24,
    parameter int          CH_BITS    = 2,
    parameter int unsigned DEF_PERIOD = 5000000,
    parameter int unsigned DEF_HIGH   = 2500000
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [CH_BITS-1:0]  cfg_ch,
    input  logic [WIDTH-1:0]    cfg_period,
    input  logic [WIDTH-1:0]    cfg_high,
    input  logic                cfg_mode,
    input  logic [CHANNELS-1:0] enable,
    input  logic [CHANNELS-1:0] start,
    input  logic                sync,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] busy
);

    if (CH_BITS < clog2(CHANNELS)) begin : g_bad_ch_bits
        $error("CH_BITS too narrow for CHANNELS");
    end

    logic [CHANNELS-1:0] w_we;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        // Indices at or above CHANNELS never match, so those
        // writes fall on the floor.
        assign w_we[gi] = cfg_we && (32'(cfg_ch) == gi);

        tick_channel #(
            .WIDTH      (WIDTH),
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_HIGH   (DEF_HIGH)
        ) u_ch (
            .clk_in   (clk_in),
            .reset    (reset),
            .i_we     (w_we[gi]),
            .i_period (cfg_period),
            .i_high   (cfg_high),
            .i_mode   (cfg_mode),
            .i_enable (enable[gi]),
            .i_start  (start[gi]),
            .i_sync   (sync),
            .o_tick   (tick[gi]),
            .o_level  (level[gi]),
            .o_busy   (busy[gi])
        );
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// tb_tick_gen_multi: directed stimulus with a per-cycle expected
// output scoreboard checked by an independent monitor.
module tb_tick_gen_multi;

    localparam int NCH = 3;
    localparam int W   = 24;

    logic           clk_in = 1'b0;
    logic           reset;
    logic           cfg_we;
    logic [1:0]     cfg_ch;
    logic [W-1:0]   cfg_period;
    logic [W-1:0]   cfg_high;
    logic           cfg_mode;
    logic [NCH-1:0] enable;
    logic [NCH-1:0] start;
    logic           sync;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] level;
    logic [NCH-1:0] busy;

    typedef struct {
        int cyc;
        int ch;
        bit t;
        bit l;
        bit b;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    tick_gen_multi #(
        .CHANNELS   (NCH),
        .WIDTH      (W),
        .CH_BITS    (2),
        .DEF_PERIOD (10),
        .DEF_HIGH   (3)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_mode   (cfg_mode),
        .enable     (enable),
        .start      (start),
        .sync       (sync),
        .tick       (tick),
        .level      (level),
        .busy       (busy)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Monitor: every cycle, retire the expectations due now.
    always @(negedge clk_in) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                checks++;
                if ({tick[q[i].ch], level[q[i].ch], busy[q[i].ch]}
                    !== {q[i].t, q[i].l, q[i].b}) begin
                    errors++;
                    $display("FAIL ch%0d cyc%0d tick/level/busy got %b%b%b want %b%b%b",
                             q[i].ch, cyc, tick[q[i].ch],
                             level[q[i].ch], busy[q[i].ch],
                             q[i].t, q[i].l, q[i].b);
                end
                q.delete(i);
            end else if (q[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale ch%0d cyc%0d never checked",
                         q[i].ch, q[i].cyc);
                q.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic expc(input int off, input int ch,
                        input bit t, input bit l, input bit b);
        q.push_back('{cyc: cyc + off, ch: ch, t: t, l: l, b: b});
    endtask

    task automatic exp_zero(input int off);
        for (int c = 0; c < NCH; c++) expc(off, c, 1'b0, 1'b0, 1'b0);
    endtask

    // Periodic waveform: first running cycle at 'off'.
    task automatic exp_per(input int ch, input int off, input int n,
                           input int p, input int h);
        for (int j = 0; j < n; j++)
            expc(off + j, ch, (j % p) == p - 1, (j % p) < h, 1'b1);
    endtask

    task automatic cfg(input int ch, input int p, input int h,
                       input bit m);
        cfg_we     = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_period = W'(p);
        cfg_high   = W'(h);
        cfg_mode   = m;
        step(1);
        cfg_we     = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_period = '0;
        cfg_high   = '0;
        cfg_mode   = 1'b0;
        enable     = '0;
        start      = '0;
        sync       = 1'b0;

        step(1);
        exp_zero(0);
        step(1);
        reset = 1'b0;
        exp_zero(1);
        step(1);

        // Default config on ch2: P=10 H=3
        enable[2] = 1'b1;
        exp_per(2, 1, 12, 10, 3);
        step(12);
        enable[2] = 1'b0;
        expc(1, 2, 1'b0, 1'b0, 1'b0);
        step(1);

        // ch0 periodic P=4 H=2
        cfg(0, 4, 2, 1'b0);
        enable[0] = 1'b1;
        exp_per(0, 1, 12, 4, 2);
        step(12);
        enable[0] = 1'b0;
        expc(1, 0, 1'b0, 1'b0, 1'b0);
        step(1);

        // ch1 one-shot P=5 H=2, retrigger while busy ignored
        cfg(1, 5, 2, 1'b1);
        enable[1] = 1'b1;
        expc(1, 1, 1'b0, 1'b0, 1'b0);
        expc(2, 1, 1'b0, 1'b0, 1'b0);
        step(2);
        start[1] = 1'b1;
        for (int j = 0; j < 5; j++)
            expc(1 + j, 1, j == 4, j < 2, 1'b1);
        for (int j = 6; j <= 8; j++) expc(j, 1, 1'b0, 1'b0, 1'b0);
        step(1);
        start[1] = 1'b0;
        step(1);
        start[1] = 1'b1;
        step(1);
        start[1] = 1'b0;
        step(6);
        start[1] = 1'b1;
        for (int j = 0; j < 5; j++)
            expc(1 + j, 1, j == 4, j < 2, 1'b1);
        expc(6, 1, 1'b0, 1'b0, 1'b0);
        expc(7, 1, 1'b0, 1'b0, 1'b0);
        step(1);
        start[1] = 1'b0;
        step(8);
        enable[1] = 1'b0;

        // ch0 P=4 -> write P=6 H=3 mid-period
        enable[0] = 1'b1;
        for (int j = 0; j < 4; j++)
            expc(1 + j, 0, j == 3, j < 2, 1'b1);
        for (int k = 0; k < 12; k++)
            expc(5 + k, 0, (k % 6) == 5, (k % 6) < 3, 1'b1);
        expc(17, 0, 1'b0, 1'b0, 1'b0);
        step(2);
        cfg(0, 6, 3, 1'b0);
        step(13);
        enable[0] = 1'b0;
        step(1);

        // Write on wrap cycle deferred; last of several writes wins
        enable[0] = 1'b1;
        for (int j = 0; j < 21; j++) begin
            if (j < 12)
                expc(1 + j, 0, (j % 6) == 5, (j % 6) < 3, 1'b1);
            else
                expc(1 + j, 0, ((j - 12) % 3) == 2,
                     ((j - 12) % 3) < 1, 1'b1);
        end
        expc(22, 0, 1'b0, 1'b0, 1'b0);
        step(6);
        cfg(0, 7, 1, 1'b0);
        cfg(0, 9, 1, 1'b0);
        cfg(0, 3, 1, 1'b0);
        step(12);
        enable[0] = 1'b0;
        step(1);

        // sync aligns ch0 and ch2 (P=8 H=4) started 3 cycles apart
        cfg(0, 8, 4, 1'b0);
        cfg(2, 8, 4, 1'b0);
        enable[0] = 1'b1;
        exp_per(0, 1, 8, 8, 4);
        step(3);
        enable[2] = 1'b1;
        exp_per(2, 1, 5, 8, 4);
        step(5);
        sync = 1'b1;
        exp_per(0, 1, 16, 8, 4);
        exp_per(2, 1, 16, 8, 4);
        step(1);
        sync = 1'b0;
        step(15);
        enable[0] = 1'b0;
        enable[2] = 1'b0;
        exp_zero(1);
        step(1);

        // P=0: never runs
        cfg(0, 0, 0, 1'b0);
        enable[0] = 1'b1;
        for (int j = 1; j <= 5; j++) expc(j, 0, 1'b0, 1'b0, 1'b0);
        step(5);
        enable[0] = 1'b0;
        step(1);

        // P=1 H=0: tick every cycle, level low
        cfg(0, 1, 0, 1'b0);
        enable[0] = 1'b1;
        exp_per(0, 1, 6, 1, 0);
        step(6);
        enable[0] = 1'b0;
        expc(1, 0, 1'b0, 1'b0, 1'b0);
        step(1);

        // H=10 > P=4: level constantly high
        cfg(0, 4, 10, 1'b0);
        enable[0] = 1'b1;
        exp_per(0, 1, 8, 4, 10);
        step(8);
        enable[0] = 1'b0;
        expc(1, 0, 1'b0, 1'b0, 1'b0);
        step(1);

        // Reset mid-period (ch0) and mid-shot (ch1)
        cfg(0, 4, 2, 1'b0);
        enable[0] = 1'b1;
        enable[1] = 1'b1;
        start[1]  = 1'b1;
        expc(1, 0, 1'b0, 1'b1, 1'b1);
        expc(1, 1, 1'b0, 1'b1, 1'b1);
        step(1);
        start[1] = 1'b0;
        cfg(0, 7, 7, 1'b1);
        reset  = 1'b1;
        enable = '0;
        exp_zero(0);
        exp_zero(1);
        step(1);
        reset = 1'b0;
        cfg(3, 2, 1, 1'b1);
        enable = '1;
        for (int c = 0; c < NCH; c++) exp_per(c, 1, 12, 10, 3);
        step(12);
        enable = '0;
        exp_zero(1);
        step(1);

        for (int k = 0; k < 50 && q.size() != 0; k++) step(1);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain %0d expectations left, want 0",
                     q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
